// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, match_len, char_nxt) tokens back into
// a character stream, one character per cycle, mirroring the encoder's search buffer.
module lz77_decoder #(
    parameter int unsigned    SB_DEPTH = 9,
    parameter int unsigned    DW       = 8,
    parameter int unsigned    OW       = 4,
    parameter int unsigned    LW       = 3,
    parameter logic [DW-1:0]  TERM     = 'h24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          code_valid,
    input  logic [OW-1:0] offset,
    input  logic [LW-1:0] match_len,
    input  logic [DW-1:0] char_nxt,
    output logic          out_valid,
    output logic [DW-1:0] out_char,
    output logic          busy,
    output logic          finish,
    output logic          err_overrun,
    output logic          err_offset
);

    typedef enum logic [1:0] {StIdle, StCopy, StLit, StDone} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [OW-1:0] off_q, off_d;
    logic [DW-1:0] char_q, char_d;
    logic [DW-1:0] sb_q [SB_DEPTH];
    logic [DW-1:0] sb_d [SB_DEPTH];
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_char_q, out_char_d;
    logic          finish_q, finish_d;
    logic          err_overrun_q, err_overrun_d;
    logic          err_offset_q, err_offset_d;

    logic          shift_en;
    logic [DW-1:0] shift_char;
    logic [DW-1:0] copy_char;

    // Search-buffer read; out-of-range offsets read as zero.
    always_comb begin
        copy_char = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (off_q == OW'(k)) begin
                copy_char = sb_q[k];
            end
        end
    end

    // Next-state, output and buffer-shift decisions.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        off_d         = off_q;
        char_d        = char_q;
        out_valid_d   = 1'b0;
        out_char_d    = out_char_q;
        finish_d      = finish_q;
        err_overrun_d = err_overrun_q;
        err_offset_d  = err_offset_q;
        shift_en      = 1'b0;
        shift_char    = '0;

        case (state_q)
            StIdle: begin
                if (code_valid) begin
                    off_d   = offset;
                    count_d = match_len;
                    char_d  = char_nxt;
                    if (32'(offset) >= SB_DEPTH) begin
                        err_offset_d = 1'b1;
                    end
                    state_d = (match_len != '0) ? StCopy : StLit;
                end
            end
            StCopy: begin
                // Tokens arriving mid-expansion are dropped but flagged.
                if (code_valid) begin
                    err_overrun_d = 1'b1;
                end
                out_char_d  = copy_char;
                out_valid_d = 1'b1;
                shift_en    = 1'b1;
                shift_char  = copy_char;
                count_d     = count_q - LW'(1);
                if (count_q == LW'(1)) begin
                    state_d = StLit;
                end
            end
            StLit: begin
                if (code_valid) begin
                    err_overrun_d = 1'b1;
                end
                if (char_q != TERM) begin
                    out_char_d  = char_q;
                    out_valid_d = 1'b1;
                    shift_en    = 1'b1;
                    shift_char  = char_q;
                    state_d     = StIdle;
                end else begin
                    finish_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Newest character enters at sb[0]; older entries age by one slot.
        for (int k = 0; k < SB_DEPTH; k++) begin
            sb_d[k] = sb_q[k];
        end
        if (shift_en) begin
            sb_d[0] = shift_char;
            for (int k = 1; k < SB_DEPTH; k++) begin
                sb_d[k] = sb_q[k-1];
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            off_q         <= '0;
            char_q        <= '0;
            sb_q          <= '{default: '0};
            out_valid_q   <= 1'b0;
            out_char_q    <= '0;
            finish_q      <= 1'b0;
            err_overrun_q <= 1'b0;
            err_offset_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            off_q         <= off_d;
            char_q        <= char_d;
            sb_q          <= sb_d;
            out_valid_q   <= out_valid_d;
            out_char_q    <= out_char_d;
            finish_q      <= finish_d;
            err_overrun_q <= err_overrun_d;
            err_offset_q  <= err_offset_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_char    = out_char_q;
    assign busy        = (state_q != StIdle);
    assign finish      = finish_q;
    assign err_overrun = err_overrun_q;
    assign err_offset  = err_offset_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: a behavioural LZ77 model pushes expected
// characters into a queue; a monitor pops and compares on every out_valid.
module tb_lz77_decoder;

    localparam int        SB   = 9;
    localparam logic [7:0] TERM = 8'h24;

    logic       clk;
    logic       reset;
    logic       code_valid;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
    logic       out_valid;
    logic [7:0] out_char;
    logic       busy;
    logic       finish;
    logic       err_overrun;
    logic       err_offset;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mb [SB];
    bit         model_done;

    lz77_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .code_valid  (code_valid),
        .offset      (offset),
        .match_len   (match_len),
        .char_nxt    (char_nxt),
        .out_valid   (out_valid),
        .out_char    (out_char),
        .busy        (busy),
        .finish      (finish),
        .err_overrun (err_overrun),
        .err_offset  (err_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every decoded character must match the head of the queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            check("out_has_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("out_char", out_char, exp_q.pop_front());
            end
        end
    end

    task automatic model_shift(input logic [7:0] c);
        for (int k = SB - 1; k > 0; k--) mb[k] = mb[k-1];
        mb[0] = c;
    endtask

    task automatic model_reset();
        for (int k = 0; k < SB; k++) mb[k] = 8'h00;
        model_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_token(input int off, input int len, input logic [7:0] ch);
        logic [7:0] c;
        if (model_done) return;
        for (int i = 0; i < len; i++) begin
            c = (off < SB) ? mb[off] : 8'h00;
            exp_q.push_back(c);
            model_shift(c);
        end
        if (ch == TERM) model_done = 1'b1;
        else begin
            exp_q.push_back(ch);
            model_shift(ch);
        end
    endtask

    // Present a token for one edge; returns at the negedge after the sampling edge.
    task automatic drive(input int off, input int len, input logic [7:0] ch);
        @(negedge clk);
        code_valid = 1'b1;
        offset     = 4'(off);
        match_len  = 3'(len);
        char_nxt   = ch;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    // Full non-terminating token: checks busy window and contiguous out_valid.
    task automatic token(input int off, input int len, input logic [7:0] ch);
        model_token(off, len, ch);
        drive(off, len, ch);
        check("busy_after_accept", busy, 1);
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            check("out_valid_run", out_valid, 1);
            if (k <= len) check("busy_during", busy, 1);
        end
        check("busy_released", busy, 0);
        @(negedge clk);
        check("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        offset     = '0;
        match_len  = '0;
        char_nxt   = '0;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_offset", err_offset, 0);
        @(negedge clk);
        reset = 1'b0;

        // Literals
        token(0, 0, "A");
        token(0, 0, "B");
        token(0, 0, "C");

        // Non-overlapping copy reproduces "ABC" then 'D'
        token(2, 3, "D");

        // Overlapping copy: 'A' then 7 copies of offset 0
        token(0, 0, "A");
        token(0, 7, "B");

        // Overrun: second token one cycle after the first is dropped
        model_token(1, 2, "E");
        drive(1, 2, "E");
        code_valid = 1'b1;
        offset     = 4'd0;
        match_len  = 3'd3;
        char_nxt   = "W";
        @(negedge clk);
        code_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun_flag", err_overrun, 1);
        check("overrun_drained", exp_q.size(), 0);
        check("overrun_idle", busy, 0);
        check("overrun_no_offset_err", err_offset, 0);

        // Out-of-range offset copies zeros
        token(12, 2, "Z");
        check("offset_flag", err_offset, 1);

        // Reset mid-copy of a length-5 token
        model_token(0, 5, "M");
        drive(0, 5, "M");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_char", out_char, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_overrun", err_overrun, 0);
        check("midrst_err_offset", err_offset, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        token(3, 2, "Q");

        // Terminator after "XY": only X is emitted, then finish sticks
        token(0, 0, "X");
        token(0, 0, "Y");
        model_token(1, 1, TERM);
        drive(1, 1, TERM);
        check("term_busy", busy, 1);
        @(negedge clk);
        check("term_copy_valid", out_valid, 1);
        check("term_finish_early", finish, 0);
        @(negedge clk);
        check("term_no_output", out_valid, 0);
        check("term_finish", finish, 1);
        model_token(0, 2, "R");
        drive(0, 2, "R");
        repeat (4) begin
            @(negedge clk);
            check("done_silent", out_valid, 0);
        end
        check("done_finish_held", finish, 1);
        check("done_no_overrun", err_overrun, 0);
        check("done_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
